fir1_decimator: RTL and testbench
=================================

# fir1_decimator

Downstream stage of the FIR1 filter: consumes the filter's signed 8-bit output stream and decimates it by integrate-and-dump. Every DECIM input samples are summed, scaled by an arithmetic right shift, and written to a small show-ahead output FIFO. The FIFO is read through a valid/ready handshake, which decouples the filter's one-sample-per-cycle rate from a slower consumer (UART, DAC interface, bus bridge).

## Interface
- DECIM, 4, decimation ratio; legal range 2..16
- SHIFT, 2, arithmetic right shift applied to the block sum; legal range 0..4
- DEPTH, 4, output FIFO depth; power of two, 2..16
- clk  input  1  system clock; all state changes on the rising edge
- rst_n  input  1  reset; asynchronous assert, active-low
- i_y  input  8  signed two's-complement sample from FIR1 o_y
- i_valid  input  1  i_y holds a new sample this cycle; tie high when FIR1 runs every cycle
- o_data  output  8  signed decimated sample at the FIFO head
- o_valid  output  1  FIFO not empty; o_data is valid
- i_ready  input  1  consumer accepts o_data this cycle
- o_drop  output  1  sticky flag: a decimated result was discarded because the FIFO was full
- o_level  output  5  current FIFO occupancy, 0..DEPTH

## Operation
- Phase counter runs 0..DECIM-1 and advances only on cycles where i_valid=1.
- Accumulator is 12-bit signed (8 bits plus 4 bits of growth). The sample is sign-extended before it is added.
- When i_valid=1 and phase<DECIM-1: acc <= acc + i_y; phase++.
- When i_valid=1 and phase==DECIM-1 (dump):
  - sum = acc + i_y
  - res = sum >>> SHIFT (arithmetic shift, rounds toward −inf)
  - res is reduced to 8 bits according to Configuration and pushed to the FIFO
  - acc <= 0; phase <= 0
- The sample on the dump cycle is included in the current block. The next block starts empty.
- Pop: occurs when o_valid && i_ready. The FIFO advances the head and o_data shows the next entry.
- Push when full with no pop in the same cycle: the result is discarded, o_drop is set to 1 and stays at 1 until reset, and the FIFO contents are unchanged.
- Push and pop in the same cycle: both are performed, including when the FIFO is full. o_level is unchanged and nothing is dropped.
- Pop when empty: cannot occur because o_valid=0; i_ready is ignored.
- Pointers wrap modulo DEPTH. Full/empty are decided by the occupancy count, not by pointer equality.
- Reset values: o_data=0, o_valid=0, o_drop=0, o_level=0, acc=0, phase=0.
- Reset mid-block discards the partial sum and any queued data. After rst_n deasserts, the first valid sample is phase 0.

## Timing
- Decimation latency: the result of the block that ends with the sample accepted at edge k is in the FIFO after edge k. If the FIFO was empty, o_valid=1 and o_data is correct in the following cycle, a latency of 1 cycle.
- o_valid, o_data and o_level are driven from registers only; there is no combinational path from i_ready or i_valid to any output.
- o_drop rises in the cycle after the dropping edge.
- Sustained throughput is one result every DECIM valid samples. With i_ready held high the FIFO occupancy never exceeds 1.

## Configuration
- FIR1_DECIM_SAT_EN defined: res is saturated to the range −128..127 before the push.
- FIR1_DECIM_SAT_EN undefined: res is truncated to its low 8 bits (two's-complement wrap).
- Default builds define the macro.

## Test plan
- Basic block (DECIM=4, SHIFT=2, i_ready=1). Input 1, −6, 10, 2 gives sum 7, so o_data=1 with o_valid high for exactly one cycle. The following block −4, −4, −4, −3 (sum −15) gives o_data=−4.
- Saturation (SHIFT=0, DECIM=4). Input 100, 100, 0, 0 gives o_data=127 with FIR1_DECIM_SAT_EN defined and −56 without it. Input −128×4 gives −128 with the macro and 0 without it.
- Back-pressure and overflow (DEPTH=4, i_ready=0, all blocks of 4×8 giving result 8). After 4 blocks o_level=4 and o_drop=0. The 5th block leaves o_level=4 and sets o_drop=1. Then raising i_ready must read out 8, 8, 8, 8, after which o_valid=0.
- Simultaneous push/pop when full. With o_level=4, assert i_ready on the dump cycle: o_level stays 4, o_drop stays 0, and the new result appears last in readout order.
- i_valid gaps. Present the samples 1, −6, 10, 2 with i_valid low for 3 cycles between each: the result is still 1, and phase does not advance during the gaps.
- Reset mid-operation. Assert rst_n=0 after 2 samples with the FIFO holding 2 entries: all outputs go to 0 immediately. After release, the block 4, 4, 4, 4 gives o_data=4 as the first output.

Source files
------------

// File: rtl/fir1_decimator.sv
// Integrate-and-dump decimator behind FIR1 with a show-ahead output FIFO.
// Define FIR1_DECIM_SAT_EN to saturate results to -128..127; otherwise they wrap.
module fir1_decimator #(
  parameter int DECIM = 4,
  parameter int SHIFT = 2,
  parameter int DEPTH = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic signed [7:0] i_y,
  input  logic              i_valid,
  output logic signed [7:0] o_data,
  output logic              o_valid,
  input  logic              i_ready,
  output logic              o_drop,
  output logic [4:0]        o_level
);

  localparam int PHW = (DECIM > 1) ? $clog2(DECIM) : 1;
  localparam int PW  = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [PHW-1:0]     phase_q, phase_d;
  logic signed [11:0] acc_q, acc_d;
  logic [PW-1:0]      rd_ptr_q, rd_ptr_d;
  logic [PW-1:0]      wr_ptr_q, wr_ptr_d;
  logic [4:0]         count_q, count_d;
  logic signed [7:0]  data_q, data_d;
  logic               valid_q, valid_d;
  logic               drop_q, drop_d;
  logic signed [7:0]  mem_q [DEPTH];

  logic               dump;
  logic               full;
  logic               pop;
  logic               push_ok;
  logic signed [11:0] sum;
  logic signed [7:0]  res8;

  assign dump = i_valid && (phase_q == PHW'(DECIM - 1));
  assign sum  = acc_q + {{4{i_y[7]}}, i_y};

`ifdef FIR1_DECIM_SAT_EN
  logic signed [11:0] res;
  assign res = sum >>> SHIFT;
  always_comb begin
    if (res > 12'sd127)
      res8 = 8'sd127;
    else if (res < -12'sd128)
      res8 = -8'sd128;
    else
      res8 = res[7:0];
  end
`else
  assign res8 = 8'(sum >>> SHIFT);
`endif

  assign full    = (count_q == 5'(DEPTH));
  assign pop     = valid_q && i_ready;
  // A full FIFO still accepts a push when the head leaves in the same cycle.
  assign push_ok = dump && (!full || pop);

  always_comb begin
    acc_d   = acc_q;
    phase_d = phase_q;
    if (i_valid) begin
      if (dump) begin
        acc_d   = '0;
        phase_d = '0;
      end else begin
        acc_d   = sum;
        phase_d = phase_q + 1'b1;
      end
    end
  end

  always_comb begin
    wr_ptr_d = push_ok ? wr_ptr_q + 1'b1 : wr_ptr_q;
    rd_ptr_d = pop ? rd_ptr_q + 1'b1 : rd_ptr_q;
    count_d  = count_q;
    if (push_ok && !pop)
      count_d = count_q + 5'd1;
    else if (!push_ok && pop)
      count_d = count_q - 5'd1;
    drop_d  = drop_q | (dump && full && !pop);
    valid_d = (count_d != 5'd0);
    // The new head bypasses the array when it is the entry being written now.
    data_d  = data_q;
    if (count_d != 5'd0) begin
      if (push_ok && (wr_ptr_q == rd_ptr_d))
        data_d = res8;
      else
        data_d = mem_q[rd_ptr_d];
    end
  end

  always_ff @(posedge clk) begin
    if (push_ok)
      mem_q[wr_ptr_q] <= res8;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      phase_q  <= '0;
      acc_q    <= '0;
      rd_ptr_q <= '0;
      wr_ptr_q <= '0;
      count_q  <= '0;
      data_q   <= '0;
      valid_q  <= 1'b0;
      drop_q   <= 1'b0;
    end else begin
      phase_q  <= phase_d;
      acc_q    <= acc_d;
      rd_ptr_q <= rd_ptr_d;
      wr_ptr_q <= wr_ptr_d;
      count_q  <= count_d;
      data_q   <= data_d;
      valid_q  <= valid_d;
      drop_q   <= drop_d;
    end
  end

  assign o_data  = data_q;
  assign o_valid = valid_q;
  assign o_drop  = drop_q;
  assign o_level = count_q;

endmodule

// File: tb/tb_fir1_decimator.sv
// Directed bench for fir1_decimator: block sums, saturation/wrap, back-pressure,
// overflow, input gaps and asynchronous reset. Expectations follow FIR1_DECIM_SAT_EN.
module tb_fir1_decimator;

  logic              clk = 1'b0;
  logic              rst_n = 1'b1;
  logic signed [7:0] i_y = '0;
  logic              i_valid = 1'b0;
  logic              i_ready = 1'b0;

  logic signed [7:0] a_data, b_data;
  logic              a_valid, b_valid;
  logic              a_drop, b_drop;
  logic [4:0]        a_level, b_level;

  int n_checks = 0;
  int n_fail   = 0;

`ifdef FIR1_DECIM_SAT_EN
  localparam int SAT_POS = 127;
  localparam int SAT_NEG = -128;
`else
  localparam int SAT_POS = -56;
  localparam int SAT_NEG = 0;
`endif

  always #5 clk = ~clk;

  // Main instance: DECIM=4, SHIFT=2, DEPTH=4
  fir1_decimator #(.DECIM(4), .SHIFT(2), .DEPTH(4)) u_dut_a (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_y     (i_y),
    .i_valid (i_valid),
    .o_data  (a_data),
    .o_valid (a_valid),
    .i_ready (i_ready),
    .o_drop  (a_drop),
    .o_level (a_level)
  );

  // Unshifted instance for the saturation cases
  fir1_decimator #(.DECIM(4), .SHIFT(0), .DEPTH(4)) u_dut_b (
    .clk     (clk),
    .rst_n   (rst_n),
    .i_y     (i_y),
    .i_valid (i_valid),
    .o_data  (b_data),
    .o_valid (b_valid),
    .i_ready (i_ready),
    .o_drop  (b_drop),
    .o_level (b_level)
  );

  task automatic check_eq(input string tag, input int obs, input int exp);
    n_checks++;
    if (obs !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, expected %0d", tag, obs, exp);
    end else begin
      $display("ok   %s: %0d", tag, obs);
    end
  endtask

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic sample(input int v);
    i_y     = 8'(v);
    i_valid = 1'b1;
    @(posedge clk);
    #1;
    i_valid = 1'b0;
  endtask

  task automatic block4(input int a, input int b, input int c, input int d);
    sample(a);
    sample(b);
    sample(c);
    sample(d);
  endtask

  task automatic do_reset();
    i_valid = 1'b0;
    i_ready = 1'b0;
    rst_n   = 1'b0;
    idle(2);
    rst_n = 1'b1;
    idle(1);
  endtask

  initial begin
    int gap_v [4];
    int exp_q [4];
    gap_v = '{1, -6, 10, 2};

    #2;
    do_reset();
    check_eq("reset_data",  int'(a_data), 0);
    check_eq("reset_valid", int'(a_valid), 0);
    check_eq("reset_level", int'(a_level), 0);
    check_eq("reset_drop",  int'(a_drop), 0);

    // Saturation / wrap on the SHIFT=0 instance
    i_ready = 1'b1;
    block4(100, 100, 0, 0);
    check_eq("sat_pos_valid", int'(b_valid), 1);
    check_eq("sat_pos_data",  int'(b_data), SAT_POS);
    block4(-128, -128, -128, -128);
    check_eq("sat_neg_valid", int'(b_valid), 1);
    check_eq("sat_neg_data",  int'(b_data), SAT_NEG);

    // Basic blocks, consumer always ready
    do_reset();
    i_ready = 1'b1;
    block4(1, -6, 10, 2);
    check_eq("basic1_valid", int'(a_valid), 1);
    check_eq("basic1_data",  int'(a_data), 1);
    check_eq("basic1_level", int'(a_level), 1);
    sample(-4);
    check_eq("basic1_popped", int'(a_valid), 0);
    sample(-4);
    sample(-4);
    sample(-3);
    check_eq("basic2_valid", int'(a_valid), 1);
    check_eq("basic2_data",  int'(a_data), -4);
    idle(1);
    check_eq("basic2_popped", int'(a_valid), 0);

    // Gaps in i_valid do not advance the phase
    for (int i = 0; i < 4; i++) begin
      sample(gap_v[i]);
      if (i < 3) begin
        idle(3);
        check_eq("gap_no_output", int'(a_valid), 0);
      end
    end
    check_eq("gap_valid", int'(a_valid), 1);
    check_eq("gap_data",  int'(a_data), 1);
    idle(1);

    // Back-pressure and overflow
    do_reset();
    for (int n = 1; n <= 4; n++) begin
      block4(8, 8, 8, 8);
      check_eq("bp_level", int'(a_level), n);
    end
    check_eq("bp_full_drop", int'(a_drop), 0);
    block4(8, 8, 8, 8);
    check_eq("ovf_level", int'(a_level), 4);
    check_eq("ovf_drop",  int'(a_drop), 1);
    i_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      check_eq("ovf_read_valid", int'(a_valid), 1);
      check_eq("ovf_read_data",  int'(a_data), 8);
      idle(1);
    end
    check_eq("ovf_empty_valid", int'(a_valid), 0);
    check_eq("ovf_empty_level", int'(a_level), 0);
    check_eq("ovf_drop_sticky", int'(a_drop), 1);

    // Push and pop on the same edge while full
    do_reset();
    for (int k = 1; k <= 4; k++)
      block4(k, k, k, k);
    check_eq("pp_full_level", int'(a_level), 4);
    sample(5);
    sample(5);
    sample(5);
    i_ready = 1'b1;
    sample(5);
    i_ready = 1'b0;
    check_eq("pp_level", int'(a_level), 4);
    check_eq("pp_drop",  int'(a_drop), 0);
    exp_q = '{2, 3, 4, 5};
    i_ready = 1'b1;
    for (int n = 0; n < 4; n++) begin
      check_eq("pp_read_valid", int'(a_valid), 1);
      check_eq("pp_read_data",  int'(a_data), exp_q[n]);
      idle(1);
    end
    check_eq("pp_empty_valid", int'(a_valid), 0);

    // Asynchronous reset mid-block with queued data
    do_reset();
    block4(1, 1, 1, 1);
    block4(2, 2, 2, 2);
    check_eq("mid_level", int'(a_level), 2);
    sample(9);
    sample(9);
    #2;
    rst_n = 1'b0;
    #1;
    check_eq("async_rst_data",  int'(a_data), 0);
    check_eq("async_rst_valid", int'(a_valid), 0);
    check_eq("async_rst_level", int'(a_level), 0);
    check_eq("async_rst_drop",  int'(a_drop), 0);
    idle(1);
    rst_n = 1'b1;
    idle(1);
    i_ready = 1'b1;
    block4(4, 4, 4, 4);
    check_eq("post_rst_valid", int'(a_valid), 1);
    check_eq("post_rst_data",  int'(a_data), 4);
    check_eq("post_rst_level", int'(a_level), 1);
    idle(2);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
